// File: rtl/st_packet_fifo_adapter.sv
// Streaming packet FIFO adapter.
// Sink and source handshakes are decoupled by a show-ahead FIFO. Source
// framing is either the stored sink sop/eop flags or a fixed-length framing
// regenerated from a beat counter that advances on each read transfer.
module st_packet_fifo_adapter #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int FRAME_MODE = 0,
    parameter int PACKET_LEN = 256
) (
    input  logic                      avalon_st_clk,
    input  logic                      avalon_st_reset,
    input  logic [DATA_WIDTH-1:0]     avalon_st_sink_data,
    input  logic                      avalon_st_sink_valid,
    output logic                      avalon_st_sink_ready,
    input  logic                      avalon_st_sink_startofpacket,
    input  logic                      avalon_st_sink_endofpacket,
    output logic [DATA_WIDTH-1:0]     avalon_st_source_data,
    output logic                      avalon_st_source_valid,
    input  logic                      avalon_st_source_ready,
    output logic                      avalon_st_source_startofpacket,
    output logic                      avalon_st_source_endofpacket,
    output logic [$clog2(DEPTH):0]    fifo_level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
    localparam int EW = DATA_WIDTH + 2;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [BW-1:0] LAST_BEAT = BW'(PACKET_LEN - 1);

    // Each entry holds {data, sop, eop}
    logic [EW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          sink_ready_q, sink_ready_d;

    logic          wr_en;
    logic          rd_en;
    logic [EW-1:0] head;

    assign avalon_st_source_valid = (count_q != '0);
    assign avalon_st_sink_ready   = sink_ready_q;
    assign fifo_level             = count_q;
    assign wr_en = avalon_st_sink_valid & sink_ready_q;
    assign rd_en = avalon_st_source_valid & avalon_st_source_ready;

    // Next pointer, occupancy and beat-counter values from this cycle's transfers.
    // Ready is precomputed from the next count so it is a plain flop output.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        beat_d   = beat_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            beat_d   = (beat_q == LAST_BEAT) ? '0 : beat_q + BW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        sink_ready_d = (count_d < DEPTH_C);
    end

    // Control state; reset discards the buffered contents and restarts framing.
    always_ff @(posedge avalon_st_clk or posedge avalon_st_reset) begin
        if (avalon_st_reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            beat_q       <= '0;
            sink_ready_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            beat_q       <= beat_d;
            sink_ready_q <= sink_ready_d;
        end
    end

    // Storage array; contents need no reset because occupancy gates visibility.
    always_ff @(posedge avalon_st_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {avalon_st_sink_data,
                                avalon_st_sink_startofpacket,
                                avalon_st_sink_endofpacket};
        end
    end

    // Show-ahead output: head entry drives the source with no read latency.
    always_comb begin
        head = mem_q[rd_ptr_q];
        avalon_st_source_data = head[EW-1:2];
        if (FRAME_MODE == 0) begin
            avalon_st_source_startofpacket = avalon_st_source_valid & head[1];
            avalon_st_source_endofpacket   = avalon_st_source_valid & head[0];
        end else begin
            avalon_st_source_startofpacket = avalon_st_source_valid & (beat_q == '0);
            avalon_st_source_endofpacket   = avalon_st_source_valid & (beat_q == LAST_BEAT);
        end
    end

endmodule

// File: tb/tb_st_packet_fifo_adapter.sv
// Directed bench: u0 forwards sink framing, u1 regenerates 4-beat packets.
module tb_st_packet_fifo_adapter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [15:0] s0_data = '0, s1_data = '0;
    logic        s0_valid = 0, s1_valid = 0;
    logic        s0_sop = 0, s0_eop = 0, s1_sop = 0, s1_eop = 0;
    logic        s0_ready, s1_ready;
    logic [15:0] o0_data, o1_data;
    logic        o0_valid, o1_valid;
    logic        o0_ready = 0, o1_ready = 0;
    logic        o0_sop, o0_eop, o1_sop, o1_eop;
    logic [3:0]  lvl0, lvl1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    st_packet_fifo_adapter #(.DATA_WIDTH(16), .DEPTH(8), .FRAME_MODE(0), .PACKET_LEN(256)) u0 (
        .avalon_st_clk(clk), .avalon_st_reset(rst),
        .avalon_st_sink_data(s0_data), .avalon_st_sink_valid(s0_valid),
        .avalon_st_sink_ready(s0_ready),
        .avalon_st_sink_startofpacket(s0_sop), .avalon_st_sink_endofpacket(s0_eop),
        .avalon_st_source_data(o0_data), .avalon_st_source_valid(o0_valid),
        .avalon_st_source_ready(o0_ready),
        .avalon_st_source_startofpacket(o0_sop), .avalon_st_source_endofpacket(o0_eop),
        .fifo_level(lvl0)
    );

    st_packet_fifo_adapter #(.DATA_WIDTH(16), .DEPTH(8), .FRAME_MODE(1), .PACKET_LEN(4)) u1 (
        .avalon_st_clk(clk), .avalon_st_reset(rst),
        .avalon_st_sink_data(s1_data), .avalon_st_sink_valid(s1_valid),
        .avalon_st_sink_ready(s1_ready),
        .avalon_st_sink_startofpacket(s1_sop), .avalon_st_sink_endofpacket(s1_eop),
        .avalon_st_source_data(o1_data), .avalon_st_source_valid(o1_valid),
        .avalon_st_source_ready(o1_ready),
        .avalon_st_source_startofpacket(o1_sop), .avalon_st_source_endofpacket(o1_eop),
        .fifo_level(lvl1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] pat;
    logic [15:0] exp_d [4];
    logic        exp_s [4];
    logic        exp_e [4];
    int          wi, ri;
    logic        wacc, racc, pv, ps, pe;
    logic [15:0] pd;

    initial begin
        pat = 32'b1011_0010_1101_0110_0111_0001_1010_1101;
        exp_d[0] = 16'h0201; exp_d[1] = 16'h0202; exp_d[2] = 16'h0203; exp_d[3] = 16'h0204;
        exp_s[0] = 1; exp_s[1] = 0; exp_s[2] = 0; exp_s[3] = 1;
        exp_e[0] = 0; exp_e[1] = 0; exp_e[2] = 1; exp_e[3] = 1;

        // reset values
        #1 rst = 1'b1;
        #2;
        chk("rst_ready0", 32'(s0_ready), 0);
        chk("rst_valid0", 32'(o0_valid), 0);
        chk("rst_level0", 32'(lvl0), 0);
        chk("rst_ready1", 32'(s1_ready), 0);
        chk("rst_sop1",   32'(o1_sop), 0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("post_rst_ready0", 32'(s0_ready), 1);
        chk("post_rst_ready1", 32'(s1_ready), 1);

        // 1: pass-through, one beat per cycle at level 1
        o0_ready = 1;
        for (int i = 0; i < 16; i++) begin
            s0_data  = 16'(i + 1);
            s0_valid = 1;
            chk("t1_sink_ready", 32'(s0_ready), 1);
            step();
            chk("t1_valid", 32'(o0_valid), 1);
            chk("t1_data",  32'(o0_data), 32'(i + 1));
            chk("t1_level", 32'(lvl0), 1);
        end
        s0_valid = 0;
        step();
        chk("t1_drain_level", 32'(lvl0), 0);
        chk("t1_drain_valid", 32'(o0_valid), 0);

        // 2: fill under backpressure
        o0_ready = 0;
        for (int c = 0; c < 8; c++) begin
            s0_data  = 16'(16'h0100 + c);
            s0_valid = 1;
            step();
            chk("t2_level", 32'(lvl0), 32'(c + 1));
            chk("t2_sink_ready", 32'(s0_ready), (c < 7) ? 1 : 0);
        end
        s0_data = 16'h0108;
        step();
        chk("t2_full_level", 32'(lvl0), 8);
        chk("t2_full_ready", 32'(s0_ready), 0);
        chk("t2_full_head",  32'(o0_data), 32'h0100);

        // 3: read at full, then steady streaming
        o0_ready = 1;
        step();
        chk("t3_level", 32'(lvl0), 7);
        chk("t3_ready", 32'(s0_ready), 1);
        chk("t3_head",  32'(o0_data), 32'h0101);
        step();
        chk("t3_stream_level_a", 32'(lvl0), 7);
        chk("t3_stream_head_a",  32'(o0_data), 32'h0102);
        s0_data = 16'h0109;
        step();
        chk("t3_stream_level_b", 32'(lvl0), 7);
        chk("t3_stream_head_b",  32'(o0_data), 32'h0103);
        s0_valid = 0;
        for (int j = 3; j < 10; j++) begin
            chk("t3_drain_valid", 32'(o0_valid), 1);
            chk("t3_drain_data",  32'(o0_data), 32'(16'h0100 + j));
            step();
        end
        chk("t3_empty_level", 32'(lvl0), 0);
        chk("t3_empty_valid", 32'(o0_valid), 0);
        chk("t3_empty_sop",   32'(o0_sop), 0);

        // 5: forwarded framing, packets of 3 and 1 beats
        wi = 0; ri = 0; pv = 0; pd = '0; ps = 0; pe = 0;
        for (int cyc = 0; cyc < 60 && ri < 4; cyc++) begin
            o0_ready = pat[cyc % 32];
            if (wi < 4) begin
                s0_valid = 1; s0_data = exp_d[wi]; s0_sop = exp_s[wi]; s0_eop = exp_e[wi];
            end else begin
                s0_valid = 0; s0_sop = 0; s0_eop = 0;
            end
            if (pv) begin
                chk("t5_stall_data", 32'(o0_data), 32'(pd));
                chk("t5_stall_sop",  32'(o0_sop), 32'(ps));
                chk("t5_stall_eop",  32'(o0_eop), 32'(pe));
            end
            wacc = s0_valid & s0_ready;
            racc = o0_valid & o0_ready;
            if (racc) begin
                chk("t5_data", 32'(o0_data), 32'(exp_d[ri]));
                chk("t5_sop",  32'(o0_sop), 32'(exp_s[ri]));
                chk("t5_eop",  32'(o0_eop), 32'(exp_e[ri]));
                ri++;
            end
            pv = o0_valid & ~o0_ready; pd = o0_data; ps = o0_sop; pe = o0_eop;
            step();
            if (wacc) wi++;
        end
        chk("t5_beats_out", 32'(ri), 4);
        s0_valid = 0; o0_ready = 0;

        // 4: regenerated framing, sink flags driven with noise
        wi = 0; ri = 0; pv = 0;
        for (int cyc = 0; cyc < 100 && ri < 12; cyc++) begin
            o1_ready = pat[(cyc + 5) % 32];
            if (wi < 12) begin
                s1_valid = 1; s1_data = 16'(16'h0301 + wi);
                s1_sop = (wi % 2) == 1; s1_eop = (wi % 2) == 0;
            end else begin
                s1_valid = 0;
            end
            if (pv) begin
                chk("t4_stall_data", 32'(o1_data), 32'(pd));
                chk("t4_stall_sop",  32'(o1_sop), 32'(ps));
                chk("t4_stall_eop",  32'(o1_eop), 32'(pe));
            end
            wacc = s1_valid & s1_ready;
            racc = o1_valid & o1_ready;
            if (racc) begin
                chk("t4_data", 32'(o1_data), 32'(16'h0301 + ri));
                chk("t4_sop",  32'(o1_sop), ((ri % 4) == 0) ? 1 : 0);
                chk("t4_eop",  32'(o1_eop), ((ri % 4) == 3) ? 1 : 0);
                ri++;
            end
            pv = o1_valid & ~o1_ready; pd = o1_data; ps = o1_sop; pe = o1_eop;
            step();
            if (wacc) wi++;
        end
        chk("t4_beats_out", 32'(ri), 12);
        s1_valid = 0; s1_sop = 0; s1_eop = 0; o1_ready = 0;
        chk("t4_level", 32'(lvl1), 0);

        // 6: reset in the middle of a packet
        for (int k = 0; k < 5; k++) begin
            s1_valid = 1; s1_data = 16'(16'h0401 + k);
            step();
        end
        s1_valid = 0;
        chk("t6_level5", 32'(lvl1), 5);
        chk("t6_head_sop", 32'(o1_sop), 1);
        o1_ready = 1;
        step();
        step();
        o1_ready = 0;
        chk("t6_level3", 32'(lvl1), 3);
        chk("t6_mid_head", 32'(o1_data), 32'h0403);
        chk("t6_mid_sop", 32'(o1_sop), 0);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(o1_valid), 0);
        chk("t6_rst_sop",   32'(o1_sop), 0);
        chk("t6_rst_eop",   32'(o1_eop), 0);
        chk("t6_rst_level", 32'(lvl1), 0);
        chk("t6_rst_ready", 32'(s1_ready), 0);
        step();
        #2 rst = 1'b0;
        step();
        chk("t6_post_ready", 32'(s1_ready), 1);
        chk("t6_post_level", 32'(lvl1), 0);
        s1_valid = 1; s1_data = 16'h0501;
        step();
        s1_valid = 0;
        chk("t6_new_valid", 32'(o1_valid), 1);
        chk("t6_new_data",  32'(o1_data), 32'h0501);
        chk("t6_new_sop",   32'(o1_sop), 1);
        chk("t6_new_eop",   32'(o1_eop), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/st_packet_fifo_adapter.md
Name: st_packet_fifo_adapter

Overview:
- Parametrised successor to the Avalon-ST sink-to-source pass-through adapter.
- Decouples sink and source handshakes with a show-ahead FIFO of configurable width and depth.
- Either forwards the incoming startofpacket/endofpacket framing or regenerates fixed-length packet framing on the source side.
- Sits between the MM-to-ST data path and downstream streaming consumers in the single avalon_st_clk domain.

Parameters:
- DATA_WIDTH, 16, width of the data bus on sink and source.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- FRAME_MODE, 0, 0 = forward sink framing, 1 = regenerate framing every PACKET_LEN beats.
- PACKET_LEN, 256, beats per regenerated packet, at least 1; used only when FRAME_MODE=1.

Ports:
- avalon_st_clk  in  1  single clock; all logic on the rising edge.
- avalon_st_reset  in  1  asynchronous, active-high reset.
- avalon_st_sink_data  in  DATA_WIDTH  input beat.
- avalon_st_sink_valid  in  1  sink beat valid.
- avalon_st_sink_ready  out  1  adapter can accept a beat.
- avalon_st_sink_startofpacket  in  1  first beat of a packet (FRAME_MODE=0).
- avalon_st_sink_endofpacket  in  1  last beat of a packet (FRAME_MODE=0).
- avalon_st_source_data  out  DATA_WIDTH  output beat.
- avalon_st_source_valid  out  1  output beat valid.
- avalon_st_source_ready  in  1  downstream accepts a beat.
- avalon_st_source_startofpacket  out  1  first beat of an output packet.
- avalon_st_source_endofpacket  out  1  last beat of an output packet.
- fifo_level  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset is asynchronous and active-high. While avalon_st_reset is asserted:
  - pointers = 0, count = 0, beat counter = 0;
  - sink_ready = 0, source_valid = 0, fifo_level = 0;
  - source sop/eop = 0 while not valid.
- First cycle after reset deassertion: sink_ready = 1.
- Storage: DEPTH entries, each DATA_WIDTH+2 bits (data, sop, eop). Write and read pointers wrap modulo DEPTH.
- Write transfer = sink_valid & sink_ready.
  - sink_ready = (count < DEPTH), driven from registered state only.
  - sink_ready has no combinational path from source_ready.
- Read transfer = source_valid & source_ready.
  - source_valid = (count != 0).
  - Show-ahead: data/sop/eop come from the entry at the read pointer, with no read latency.
- Latency: a beat written into an empty FIFO at edge N is presented with source_valid = 1 in the cycle after edge N. Minimum latency is 1 cycle.
- Throughput: 1 beat/cycle when both sides are continuously ready.
- Count update:
  - +1 on write only, -1 on read only.
  - Unchanged on simultaneous write and read.
  - fifo_level = count.
- Full: sink_ready = 0. A sink beat held valid waits; no data is dropped or overwritten. A read while full frees a slot, and sink_ready rises in the next cycle.
- Empty: source_valid = 0. source_data is don't-care; sop/eop are forced to 0.
- Data is never reordered, duplicated or lost.
- FRAME_MODE=0:
  - Source sop/eop are the stored sink flags, passed through unchanged.
  - No framing checks are made.
- FRAME_MODE=1:
  - Sink sop/eop are ignored.
  - A beat counter counts 0..PACKET_LEN-1 and advances only on a read transfer, wrapping to 0 after PACKET_LEN-1.
  - source_startofpacket = source_valid & (beat counter == 0).
  - source_endofpacket = source_valid & (beat counter == PACKET_LEN-1).
  - PACKET_LEN = 1: every valid beat has both sop and eop.
- Backpressure stability: while source_valid = 1 and source_ready = 0, data, sop and eop stay stable.
- Reset mid-operation: FIFO contents are discarded and the beat counter returns to 0. The first beat after reset starts a new packet.

Test Plan:
1. Pass-through (DEPTH=8, FRAME_MODE=0): drive 0x0001..0x0010 back-to-back with source_ready = 1.
   -> Identical sequence out, one beat/cycle, first beat one cycle after first write, fifo_level <= 1.
2. Fill and backpressure: source_ready = 0, drive 10 beats.
   -> 8 accepted, sink_ready = 0 from the cycle after the 8th, fifo_level = 8.
   Then source_ready = 1 -> beats 0..9 emitted in order, no loss.
3. Simultaneous read and write at full: at level 8, sink_valid = 1 and source_ready = 1 for one cycle.
   -> One beat leaves, level 7, sink_ready = 1 next cycle, level then remains steady under continuous streaming.
4. Framing regeneration (FRAME_MODE=1, PACKET_LEN=4): stream 10 beats with random source_ready stalls.
   -> sop on beats 0, 4, 8; eop on beats 3, 7; sop/eop stable during stalls; sink sop/eop ignored.
5. Forwarded framing (FRAME_MODE=0): packets of 3 and 1 beats (sop+eop on the single beat) under random backpressure.
   -> Flags emerge aligned to their data beats.
6. Reset mid-packet (FRAME_MODE=1, PACKET_LEN=4, 5 beats buffered, 2 read): assert reset asynchronously.
   -> Outputs zero immediately. After release, the next beat carries sop and fifo_level = 0 before any write.
